// File: rtl/i2c_master.sv
// I2C initiator: START, slave address + R/W, register address, one data byte
// written or read, then STOP. Host side is a start/done handshake.
module i2c_master #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned QDIV       = 4
) (
  input  logic                  dclk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rw,
  input  logic [6:0]            slv_addr,
  input  logic [7:0]            reg_addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  ack_err,
  output logic                  scl,
  inout  wire                   sda
);

  localparam int unsigned QW = (QDIV > 1) ? $clog2(QDIV) : 1;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, REG, REG_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_NACK, STOP
  } state_t;

  state_t                state, stateNext;
  logic [QW-1:0]         qCnt, qCntNext;
  logic [1:0]            quarter, quarterNext;
  logic [2:0]            bitCnt, bitCntNext;
  logic                  rwLat;
  logic [6:0]            slvLat;
  logic [7:0]            regLat;
  logic [DATA_WIDTH-1:0] wdLat;
  logic [DATA_WIDTH-1:0] rxShift;
  logic                  sdaLow, sdaLowNext, sclNext;
  logic                  sdaIn;
  logic                  quarterEnd, bitEnd, samplePt, stateEnd;
  logic [7:0]            txByte;

  // Open-drain: only ever pull low; the bus pull-up supplies the 1.
  assign sda   = sdaLow ? 1'b0 : 1'bz;
  assign sdaIn = sda;

  // Sequencing: quarter/bit counters, phase transitions, next bus levels.
  always_comb begin
    stateNext   = state;
    qCntNext    = qCnt;
    quarterNext = quarter;
    bitCntNext  = bitCnt;
    sclNext     = 1'b1;
    sdaLowNext  = 1'b0;
    txByte      = 8'h00;

    quarterEnd = (qCnt == QW'(QDIV - 1));
    bitEnd     = quarterEnd && (quarter == 2'd3);
    samplePt   = quarterEnd && (quarter == 2'd2);
    stateEnd   = bitEnd && (!(state inside {ADDR, REG, WDATA, RDATA}) || (bitCnt == 3'd0));

    if (state == IDLE) begin
      qCntNext    = '0;
      quarterNext = 2'd0;
      bitCntNext  = start ? 3'd7 : 3'd0;
      if (start) stateNext = START;
    end else begin
      qCntNext    = quarterEnd ? '0 : qCnt + 1'b1;
      quarterNext = quarterEnd ? quarter + 2'd1 : quarter;
      bitCntNext  = bitEnd ? bitCnt - 3'd1 : bitCnt;
      if (stateEnd) begin
        bitCntNext = 3'd7;
        unique case (state)
          START:      stateNext = ADDR;
          ADDR:       stateNext = ADDR_ACK;
          ADDR_ACK:   stateNext = ack_err ? STOP : REG;
          REG:        stateNext = REG_ACK;
          REG_ACK:    stateNext = ack_err ? STOP : (rwLat ? RDATA : WDATA);
          WDATA:      stateNext = WDATA_ACK;
          WDATA_ACK:  stateNext = STOP;
          RDATA:      stateNext = RDATA_NACK;
          RDATA_NACK: stateNext = STOP;
          STOP:       stateNext = IDLE;
          default:    stateNext = IDLE;
        endcase
      end
    end

    unique case (stateNext)
      ADDR:    txByte = {slvLat, rwLat};
      REG:     txByte = regLat;
      WDATA:   txByte = 8'(wdLat);
      default: txByte = 8'h00;
    endcase

    // Bus levels for the phase/quarter the registers are about to enter.
    unique case (stateNext)
      IDLE: begin
        sclNext    = 1'b1;
        sdaLowNext = 1'b0;
      end
      START: begin
        sclNext    = 1'b1;
        sdaLowNext = quarterNext[1];
      end
      STOP: begin
        sclNext    = (quarterNext != 2'd0);
        sdaLowNext = !quarterNext[1];
      end
      ADDR, REG, WDATA: begin
        sclNext    = (quarterNext == 2'd1) || (quarterNext == 2'd2);
        sdaLowNext = !txByte[bitCntNext];
      end
      default: begin
        sclNext    = (quarterNext == 2'd1) || (quarterNext == 2'd2);
        sdaLowNext = 1'b0;
      end
    endcase
  end

  // Registered state, counters, bus pins and host-side status.
  always_ff @(posedge dclk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      qCnt    <= '0;
      quarter <= 2'd0;
      bitCnt  <= 3'd0;
      rwLat   <= 1'b0;
      slvLat  <= 7'd0;
      regLat  <= 8'd0;
      wdLat   <= '0;
      rxShift <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      scl     <= 1'b1;
      sdaLow  <= 1'b0;
    end else begin
      state   <= stateNext;
      qCnt    <= qCntNext;
      quarter <= quarterNext;
      bitCnt  <= bitCntNext;
      scl     <= sclNext;
      sdaLow  <= sdaLowNext;
      done    <= 1'b0;

      if (state == IDLE && start) begin
        rwLat   <= rw;
        slvLat  <= slv_addr;
        regLat  <= reg_addr;
        wdLat   <= wdata;
        ack_err <= 1'b0;
        busy    <= 1'b1;
      end

      if (samplePt && (state inside {ADDR_ACK, REG_ACK, WDATA_ACK}) && sdaIn)
        ack_err <= 1'b1;

      if (samplePt && state == RDATA)
        rxShift <= {rxShift[DATA_WIDTH-2:0], sdaIn};

      if (stateEnd && state == RDATA_NACK)
        rdata <= rxShift;

      if (stateEnd && state == STOP) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule
